// File: rtl/seg_pkg.sv
// Package for the 7-segment scan driver.
// Holds the segment patterns ({a,b,c,d,e,f,g}, a = MSB, active-high) and the
// code-to-segment lookup shared by the decoder.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;

  // Codes 10-15 only light up when hex display is enabled; otherwise blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code, input logic hex_en);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (code)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      4'hA: seg = hex_en ? SEG_A : SEG_BLANK;
      4'hB: seg = hex_en ? SEG_B : SEG_BLANK;
      4'hC: seg = hex_en ? SEG_C : SEG_BLANK;
      4'hD: seg = hex_en ? SEG_D : SEG_BLANK;
      4'hE: seg = hex_en ? SEG_E : SEG_BLANK;
      4'hF: seg = hex_en ? SEG_F : SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational 4-bit code to 7-segment decoder.
// Ports:
//   code  in  4  digit code (0-15)
//   blank in  1  force all segments off
//   seg   out 7  {a,b,c,d,e,f,g}, inverted when SEG_ACT_LOW = 1
module seg_decode
  import seg_pkg::*;
#(
  parameter int HEX_EN      = 0,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);

  localparam logic HEX_ON = (HEX_EN != 0);
  localparam logic ACT_LO = (SEG_ACT_LOW != 0);

  logic [6:0] seg_raw;

  always_comb begin
    seg_raw = blank ? SEG_BLANK : bcd_to_seg(code, HEX_ON);
    seg     = ACT_LO ? ~seg_raw : seg_raw;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver for the washer front panel.
// One digit is driven per scan slot; a frame of digits is snapshotted when the
// scan wraps to digit 0 so a frame never mixes two samples.
// Ports:
//   qclock      in  1           system clock
//   reset       in  1           synchronous, active-high reset
//   digits      in  4*N_DIGITS  digit i = digits[4i+3:4i], digit 0 least significant
//   blink_mask  in  N_DIGITS    1 = digit i blinks
//   lz_blank    in  1           1 = suppress leading zeros
//   discode     out 7           segments {a,b,c,d,e,f,g}
//   enable      out N_DIGITS    one-hot digit select, active-high
//   frame_start out 1           one-cycle pulse when the digit 0 slot begins
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_EN       = 0,
  parameter int SEG_ACT_LOW  = 0
) (
  input  logic                  qclock,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lz_blank,
  output logic [6:0]            discode,
  output logic [N_DIGITS-1:0]   enable,
  output logic                  frame_start
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FR_LAST  = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_OFF  = (SEG_ACT_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

  logic [PW-1:0]         ps_q;
  logic [IW-1:0]         idx_q, idx_nxt;
  logic [FW-1:0]         fr_q, fr_nxt;
  logic                  phase_q, phase_nxt;   // 1 = blinking digits shown
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_blink;

  logic                  tick, wrap, running;
  logic [4*N_DIGITS-1:0] cur_digits;
  logic [N_DIGITS-1:0]   cur_blink, lz_mask, en_nxt;
  logic [3:0]            cur_code;
  logic                  cur_bl, cur_lz, cur_blank;
  logic [6:0]            seg_d;

  logic [6:0]            seg_p1;
  logic [N_DIGITS-1:0]   en_p1;
  logic                  fs_p1;

  assign tick    = (ps_q == PS_LAST);
  assign wrap    = tick && (idx_q == IDX_LAST);
  assign idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  // The wrap that starts the scan after reset does not close a frame, so it
  // is not counted; this gives every blink half-period a full BLINK_FRAMES.
  assign running = |en_p1;

  // On the wrap edge the snapshot is being loaded, so slot 0 reads the live
  // inputs directly; every other slot reads the snapshot.
  assign cur_digits = wrap ? digits : snap_digits;
  assign cur_blink  = wrap ? blink_mask : snap_blink;

  always_comb begin
    fr_nxt    = fr_q;
    phase_nxt = phase_q;
    if (wrap && running) begin
      if (fr_q == FR_LAST) begin
        fr_nxt    = '0;
        phase_nxt = ~phase_q;
      end else begin
        fr_nxt = fr_q + 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every higher digit are zero.
  // Digit 0 is never flagged.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero && (cur_digits[4*i +: 4] == 4'd0);
      lz_mask[i] = all_zero;
    end
  end

  always_comb begin
    cur_code = 4'd0;
    cur_bl   = 1'b0;
    cur_lz   = 1'b0;
    en_nxt   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        cur_code  = cur_digits[4*i +: 4];
        cur_bl    = cur_blink[i];
        cur_lz    = lz_mask[i];
        en_nxt[i] = 1'b1;
      end
    end
  end

  assign cur_blank = (cur_bl && !phase_nxt) || (lz_blank && cur_lz);

  seg_decode #(
    .HEX_EN      (HEX_EN),
    .SEG_ACT_LOW (SEG_ACT_LOW)
  ) u_decode (
    .code  (cur_code),
    .blank (cur_blank),
    .seg   (seg_d)
  );

  // Stage p1: scan state and registered pin outputs
  always_ff @(posedge qclock) begin
    if (reset) begin
      ps_q    <= '0;
      idx_q   <= IDX_LAST;
      fr_q    <= '0;
      phase_q <= 1'b1;
      seg_p1  <= SEG_OFF;
      en_p1   <= '0;
      fs_p1   <= 1'b0;
    end else begin
      fs_p1 <= 1'b0;
      ps_q  <= tick ? '0 : ps_q + 1'b1;
      if (tick) begin
        idx_q   <= idx_nxt;
        fr_q    <= fr_nxt;
        phase_q <= phase_nxt;
        seg_p1  <= seg_d;
        en_p1   <= en_nxt;
        fs_p1   <= wrap;
      end
    end
  end

  always_ff @(posedge qclock) begin
    if (wrap) begin
      snap_digits <= digits;
      snap_blink  <= blink_mask;
    end
  end

  assign discode     = seg_p1;
  assign enable      = en_p1;
  assign frame_start = fs_p1;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int SD = 4;

  localparam logic [6:0] BL = 7'b0000000;
  localparam logic [6:0] L0 = 7'b1111110;
  localparam logic [6:0] L1 = 7'b0110000;
  localparam logic [6:0] L2 = 7'b1101101;
  localparam logic [6:0] L3 = 7'b1111001;
  localparam logic [6:0] L4 = 7'b0110011;
  localparam logic [6:0] L5 = 7'b1011011;
  localparam logic [6:0] L7 = 7'b1110000;
  localparam logic [6:0] L8 = 7'b1111111;
  localparam logic [6:0] L9 = 7'b1111011;
  localparam logic [6:0] LA = 7'b1110111;
  localparam logic [6:0] LF = 7'b1000111;

  logic        qclock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  blink_mask = 4'b0000;
  logic        lz_blank = 1'b0;

  logic [6:0]  discode, discode_hex, discode_al;
  logic [3:0]  enable, enable_hex, enable_al;
  logic        frame_start, fs_hex, fs_al;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] en;
    logic [6:0] seg;
    logic [6:0] seg_hex;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0]     digits;
    logic            lz;
    logic [3:0][6:0] e;
    logic [3:0][6:0] h;
  } vec_t;
  vec_t vt[7];

  seg_scan_driver #(.N_DIGITS(4), .SCAN_DIV(SD), .BLINK_FRAMES(2), .HEX_EN(0), .SEG_ACT_LOW(0)) dut (
    .qclock(qclock), .reset(reset), .digits(digits), .blink_mask(blink_mask), .lz_blank(lz_blank),
    .discode(discode), .enable(enable), .frame_start(frame_start));

  seg_scan_driver #(.N_DIGITS(4), .SCAN_DIV(SD), .BLINK_FRAMES(2), .HEX_EN(1), .SEG_ACT_LOW(0)) dut_hex (
    .qclock(qclock), .reset(reset), .digits(digits), .blink_mask(blink_mask), .lz_blank(lz_blank),
    .discode(discode_hex), .enable(enable_hex), .frame_start(fs_hex));

  seg_scan_driver #(.N_DIGITS(4), .SCAN_DIV(SD), .BLINK_FRAMES(2), .HEX_EN(0), .SEG_ACT_LOW(1)) dut_al (
    .qclock(qclock), .reset(reset), .digits(digits), .blink_mask(blink_mask), .lz_blank(lz_blank),
    .discode(discode_al), .enable(enable_al), .frame_start(fs_al));

  always #5 qclock = ~qclock;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_frame(input logic [3:0][6:0] e, input logic [3:0][6:0] h);
    for (int s = 0; s < 4; s++) sb.push_back('{en: 4'(1 << s), seg: e[s], seg_hex: h[s]});
  endtask

  task automatic step();
    repeat (SD) @(negedge qclock);
  endtask

  task automatic check_slot(input int s);
    exp_t e;
    logic [6:0] inv;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty slot=%0d", s);
      return;
    end
    e   = sb.pop_front();
    inv = ~e.seg;
    cmp($sformatf("enable_s%0d", s), 32'(enable), 32'(e.en));
    cmp($sformatf("discode_s%0d", s), 32'(discode), 32'(e.seg));
    cmp($sformatf("discode_hex_s%0d", s), 32'(discode_hex), 32'(e.seg_hex));
    cmp($sformatf("discode_al_s%0d", s), 32'(discode_al), 32'(inv));
    cmp($sformatf("enable_hex_s%0d", s), 32'(enable_hex), 32'(e.en));
    cmp($sformatf("enable_al_s%0d", s), 32'(enable_al), 32'(e.en));
    cmp($sformatf("frame_start_s%0d", s), 32'({fs_al, fs_hex, frame_start}), (s == 0) ? 32'h7 : 32'h0);
  endtask

  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge qclock);
      cyc++;
    end while (!frame_start && cyc < 64);
    if (!frame_start) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_timeout actual=%0d required=<64 cycles", cyc);
    end
  endtask

  task automatic check_frame();
    int c;
    wait_frame(c);
    for (int s = 0; s < 4; s++) begin
      check_slot(s);
      if (s < 3) step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    vt[0] = '{digits: 16'h1234, lz: 1'b0, e: {L1, L2, L3, L4}, h: {L1, L2, L3, L4}};
    vt[1] = '{digits: 16'h0070, lz: 1'b1, e: {BL, BL, L7, L0}, h: {BL, BL, L7, L0}};
    vt[2] = '{digits: 16'h0000, lz: 1'b1, e: {BL, BL, BL, L0}, h: {BL, BL, BL, L0}};
    vt[3] = '{digits: 16'h0070, lz: 1'b0, e: {L0, L0, L7, L0}, h: {L0, L0, L7, L0}};
    vt[4] = '{digits: 16'h00A0, lz: 1'b0, e: {L0, L0, BL, L0}, h: {L0, L0, LA, L0}};
    vt[5] = '{digits: 16'h0F05, lz: 1'b1, e: {BL, BL, L0, L5}, h: {BL, LF, L0, L5}};
    vt[6] = '{digits: 16'h8009, lz: 1'b1, e: {L8, L0, L0, L9}, h: {L8, L0, L0, L9}};

    // Reset held three cycles
    repeat (3) @(negedge qclock);
    cmp("reset_enable", 32'(enable), 32'h0);
    cmp("reset_discode", 32'(discode), 32'h0);
    cmp("reset_discode_al", 32'(discode_al), 32'h7F);
    cmp("reset_frame_start", 32'(frame_start), 32'h0);
    push_frame({L1, L2, L3, L4}, {L1, L2, L3, L4});
    reset = 1'b0;

    // No digit selected until the first tick on the fourth edge
    for (int k = 1; k <= 3; k++) begin
      @(negedge qclock);
      cmp($sformatf("pre_tick_enable_c%0d", k), 32'(enable), 32'h0);
      cmp($sformatf("pre_tick_discode_c%0d", k), 32'(discode), 32'h0);
    end
    @(negedge qclock);
    for (int s = 0; s < 4; s++) begin
      check_slot(s);
      if (s < 3) step();
    end

    // Scan returns to digit 0; frame period is 16 cycles
    wait_frame(c);
    cmp("slot3_to_frame_cycles", 32'(c), 32'd4);
    cmp("wrap_enable", 32'(enable), 32'h1);
    wait_frame(c);
    cmp("frame_period", 32'(c), 32'd16);

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      digits     = vt[v].digits;
      lz_blank   = vt[v].lz;
      blink_mask = 4'b0000;
      push_frame(vt[v].e, vt[v].h);
      check_frame();
    end

    // Mid-frame digit change only shows from the next frame
    digits   = 16'h1111;
    lz_blank = 1'b0;
    push_frame({L1, L1, L1, L1}, {L1, L1, L1, L1});
    wait_frame(c);
    check_slot(0);
    step();
    digits = 16'h2222;
    push_frame({L2, L2, L2, L2}, {L2, L2, L2, L2});
    check_slot(1);
    step();
    check_slot(2);
    step();
    check_slot(3);
    check_frame();

    // Reset during slot 2
    wait_frame(c);
    step();
    step();
    reset = 1'b1;
    @(negedge qclock);
    cmp("midreset_enable", 32'(enable), 32'h0);
    cmp("midreset_discode", 32'(discode), 32'h0);
    cmp("midreset_discode_al", 32'(discode_al), 32'h7F);
    cmp("midreset_frame_start", 32'(frame_start), 32'h0);
    repeat (2) @(negedge qclock);

    // Blink on digit 1: two frames shown, two blank, then shown again
    digits     = 16'h1234;
    blink_mask = 4'b0010;
    lz_blank   = 1'b0;
    push_frame({L1, L2, L3, L4}, {L1, L2, L3, L4});
    push_frame({L1, L2, L3, L4}, {L1, L2, L3, L4});
    push_frame({L1, L2, BL, L4}, {L1, L2, BL, L4});
    push_frame({L1, L2, BL, L4}, {L1, L2, BL, L4});
    push_frame({L1, L2, L3, L4}, {L1, L2, L3, L4});
    reset = 1'b0;
    for (int f = 0; f < 5; f++) check_frame();

    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
